// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//   4x4 matrix keypad scanner and debouncer for the calculator input path.
//   Rows are driven low one at a time. Columns (pulled up, active-low) are
//   synchronized into the CLK_1K domain. A press that stays stable through
//   debounce produces one flag pulse carrying the 4-bit key code.
//
// Ports
//   CLK_1K     in   1  1 kHz system clock
//   RST        in   1  asynchronous active-low reset
//   col_n      in   4  keypad columns, active-low, asynchronous
//   row_n      out  4  keypad row drive, active-low one-hot
//   key_value  out  4  code of the last debounced key, held until next press
//   flag       out  1  one-cycle pulse when key_value takes a new code
//   key_down   out  1  high while a debounced key is held
// ---------------------------------------------------------------------------
module keypad_scanner #(
  parameter int ROW_HOLD = 4,   // cycles each row is driven (>= 3)
  parameter int DEB_CNT  = 20   // stable samples for press and for release
) (
  input  logic       CLK_1K,
  input  logic       RST,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_value,
  output logic       flag,
  output logic       key_down
);

  localparam int HW = (ROW_HOLD > 1) ? $clog2(ROW_HOLD) : 1;
  localparam int DW = $clog2(DEB_CNT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(ROW_HOLD - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CNT);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

  state_t          state, state_d;
  logic [3:0]      col_meta, cols_s;
  logic [1:0]      row, row_d;          // also the latched row outside SCAN
  logic [HW-1:0]   hold_cnt, hold_d;
  logic [DW-1:0]   deb_cnt, deb_d;
  logic [1:0]      lat_col, lat_col_d;
  logic [3:0]      key_value_d;
  logic            flag_d, key_down_d;
  logic [1:0]      low_col;
  logic            any_low, lat_low;

  // Physical key legend, indexed by {row, col}.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_code = 4'h1;  4'h1: key_code = 4'h2;
      4'h2: key_code = 4'h3;  4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;  4'h5: key_code = 4'h5;
      4'h6: key_code = 4'h6;  4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;  4'h9: key_code = 4'h8;
      4'hA: key_code = 4'h9;  4'hB: key_code = 4'hC;
      4'hC: key_code = 4'hF;  4'hD: key_code = 4'h0;
      4'hE: key_code = 4'hE;  default: key_code = 4'hD;
    endcase
  endfunction

  // NOTE: the synchronizer resets to all-ones (no key) so that leaving reset
  // can never look like a press.
  always_ff @(posedge CLK_1K or negedge RST) begin
    if (!RST) begin
      col_meta <= 4'hF;
      cols_s   <= 4'hF;
    end else begin
      // NOTE: non-blocking assignments make the two flops a true shift chain.
      col_meta <= col_n;
      cols_s   <= col_meta;
    end
  end

  // Lowest low column wins when several are pressed in the same row.
  always_comb begin
    low_col = 2'd3;
    for (int c = 3; c >= 0; c--) begin
      if (!cols_s[c]) low_col = 2'(c);
    end
  end

  assign any_low = ~&cols_s;
  assign lat_low = ~cols_s[lat_col];
  assign row_n   = ~(4'b0001 << row);

  // NOTE: every output of this block gets a default first so no latch forms.
  always_comb begin
    state_d     = state;
    row_d       = row;
    hold_d      = hold_cnt;
    deb_d       = deb_cnt;
    lat_col_d   = lat_col;
    key_value_d = key_value;
    flag_d      = 1'b0;
    key_down_d  = key_down;
    case (state)
      SCAN: begin
        if (hold_cnt == HOLD_LAST) begin
          hold_d = '0;
          if (any_low) begin
            state_d   = DEBOUNCE;          // row stays driven
            lat_col_d = low_col;
            deb_d     = DW'(1);
          end else begin
            row_d = row + 2'd1;
          end
        end else begin
          hold_d = hold_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (lat_low) begin
          if (deb_cnt == DEB_MAX) begin
            state_d     = HOLD;
            key_value_d = key_code(row, lat_col);
            flag_d      = 1'b1;
            key_down_d  = 1'b1;
          end else begin
            deb_d = deb_cnt + 1'b1;        // stops at DEB_MAX, cannot wrap
          end
        end else begin
          state_d = SCAN;                  // bounce: move on to the next row
          row_d   = row + 2'd1;
        end
      end
      HOLD: begin
        if (!lat_low) begin
          state_d = RELEASE;
          deb_d   = DW'(1);
        end
      end
      RELEASE: begin
        if (!lat_low) begin
          if (deb_cnt == DEB_MAX) begin
            state_d    = SCAN;
            key_down_d = 1'b0;
            row_d      = row + 2'd1;
          end else begin
            deb_d = deb_cnt + 1'b1;
          end
        end else begin
          state_d = HOLD;                  // release bounce, no new flag
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge CLK_1K or negedge RST) begin
    if (!RST) begin
      state     <= SCAN;
      row       <= '0;
      hold_cnt  <= '0;
      deb_cnt   <= '0;
      lat_col   <= '0;
      key_value <= '0;
      flag      <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_d;
      row       <= row_d;
      hold_cnt  <= hold_d;
      deb_cnt   <= deb_d;
      lat_col   <= lat_col_d;
      key_value <= key_value_d;
      flag      <= flag_d;
      key_down  <= key_down_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//   Drives a simulated 4x4 keypad (a pressed key shorts its row to its
//   column) and compares keypad_scanner outputs every cycle against a
//   behavioural model built from the key legend and the scan/debounce rules.
//   Directed scenarios add literal expectations on key codes, flag counts,
//   latency and reset behaviour.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int RH = 4;
  localparam int DC = 20;

  logic       CLK_1K = 1'b0;
  logic       RST    = 1'b0;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_value;
  logic       flag;
  logic       key_down;
  logic [15:0] keys = '0;   // bit r*4+c set while key at row r, col c is pressed

  keypad_scanner #(.ROW_HOLD(RH), .DEB_CNT(DC)) dut (
    .CLK_1K    (CLK_1K),
    .RST       (RST),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_value (key_value),
    .flag      (flag),
    .key_down  (key_down)
  );

  always #5 CLK_1K = ~CLK_1K;

  // Keypad matrix: a column reads low when a pressed key sits on a driven row.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ------------------------------------------------------------- model ----
  string legend = "123A456B789CF0ED";

  function automatic logic [3:0] hex_of(input byte ch);
    if (ch >= 8'h30 && ch <= 8'h39) return 4'(ch - 8'h30);
    return 4'(ch - 8'h41 + 8'd10);
  endfunction

  typedef enum {M_SCAN, M_CONFIRM, M_HELD, M_LETGO} mode_t;
  mode_t      m_mode;
  int         m_t;      // position in the 4*RH scan period
  int         m_run;    // consecutive agreeing samples in CONFIRM/LETGO
  int         m_col;
  logic [3:0] p1, p2;   // column values seen one and two edges ago
  logic [3:0] exp_kv;
  logic       exp_flag, exp_kd;

  function automatic int next_row_start(input int t);
    return ((t / RH + 1) % 4) * RH;
  endfunction

  initial forever begin
    @(posedge CLK_1K or negedge RST);
    if (!RST) begin
      m_mode = M_SCAN; m_t = 0; m_run = 0; m_col = 0;
      p1 = 4'hF; p2 = 4'hF;
      exp_kv = 4'h0; exp_flag = 1'b0; exp_kd = 1'b0;
    end else begin
      automatic logic [3:0] s = p2;
      automatic bit found = 1'b0;
      p2 = p1;
      p1 = col_n;
      exp_flag = 1'b0;
      case (m_mode)
        M_SCAN: begin
          if (m_t % RH == RH - 1 && s != 4'hF) begin
            for (int c = 0; c < 4; c++)
              if (!found && !s[c]) begin m_col = c; found = 1'b1; end
            m_mode = M_CONFIRM;
            m_run  = 1;
          end else begin
            m_t = (m_t + 1) % (4 * RH);
          end
        end
        M_CONFIRM: begin
          if (!s[m_col]) begin
            m_run++;
            if (m_run == DC + 1) begin
              exp_kv   = hex_of(legend[(m_t / RH) * 4 + m_col]);
              exp_flag = 1'b1;
              exp_kd   = 1'b1;
              m_mode   = M_HELD;
            end
          end else begin
            m_mode = M_SCAN;
            m_t    = next_row_start(m_t);
          end
        end
        M_HELD: begin
          if (s[m_col]) begin m_mode = M_LETGO; m_run = 1; end
        end
        default: begin
          if (s[m_col]) begin
            m_run++;
            if (m_run == DC + 1) begin
              exp_kd = 1'b0;
              m_mode = M_SCAN;
              m_t    = next_row_start(m_t);
            end
          end else begin
            m_mode = M_HELD;
          end
        end
      endcase
    end
  end

  // --------------------------------------------------- compare/monitor ----
  int         flag_cnt = 0;
  logic [3:0] flag_log[$];

  initial forever begin
    @(negedge CLK_1K);
    if (RST) begin
      automatic logic [3:0] exp_row = 4'b1111 ^ (4'b0001 << (m_t / RH));
      check("row_n", row_n, exp_row);
      check("flag", flag, exp_flag);
      check("key_value", key_value, exp_kv);
      check("key_down", key_down, exp_kd);
      if (flag) begin
        flag_cnt++;
        flag_log.push_back(key_value);
      end
    end
  end

  // ------------------------------------------------------- stimulus ----
  task automatic cyc(input int n);
    repeat (n) begin @(negedge CLK_1K); #1; end
  endtask

  task automatic press(input int idx);
    keys[idx] = 1'b1;
  endtask

  task automatic unpress(input int idx);
    keys[idx] = 1'b0;
  endtask

  task automatic wait_row(input string name, input logic [3:0] want, input bit entering);
    logic [3:0] prev = row_n;
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      cyc(1);
      if (row_n == want && (!entering || prev != want)) seen = 1'b1;
      prev = row_n;
    end
    if (!seen) check({name, " row wait"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_flag(input string name, input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget && lat < 0; i++) begin
      cyc(1);
      if (flag) lat = i;
    end
    check({name, " flag seen"}, 32'(lat > 0), 32'd1);
  endtask

  initial begin
    int n0, lat, base;
    int seq_idx[5];
    logic [3:0] seq_exp[5];
    seq_idx = '{0, 1, 3, 2, 14};
    seq_exp = '{4'h1, 4'h2, 4'hA, 4'h3, 4'hE};

    #2;
    check("reset row_n", row_n, 4'b1110);
    check("reset flag", flag, 1'b0);
    check("reset key_value", key_value, 4'h0);
    check("reset key_down", key_down, 1'b0);
    cyc(3);
    RST = 1'b1;
    cyc(20);

    // Clean press of key 6 (row1/col2), held 60 cycles.
    n0 = flag_cnt;
    wait_row("t1", 4'b1101, 1'b0);
    press(6);
    wait_flag("t1", 60, lat);
    check("t1 latency ok", 32'(lat > 0 && lat <= 38), 32'd1);
    check("t1 key_value", key_value, 4'h6);
    if (lat > 0 && lat < 60) cyc(60 - lat);
    check("t1 one flag", flag_cnt - n0, 1);
    unpress(6);
    cyc(20);
    check("t1 key_down held", key_down, 1'b1);
    cyc(10);
    check("t1 key_down clear", key_down, 1'b0);

    // Bounce: key 7 (row2/col0) low for 10 cycles from the start of row 2.
    n0 = flag_cnt;
    wait_row("t2", 4'b1011, 1'b1);
    press(8);
    cyc(10);
    unpress(8);
    cyc(30);
    check("t2 no flag", flag_cnt - n0, 0);
    check("t2 key_value kept", key_value, 4'h6);
    wait_row("t2", 4'b1110, 1'b1);
    cyc(4);
    check("t2 scan row1", row_n, 4'b1101);
    cyc(4);
    check("t2 scan row2", row_n, 4'b1011);
    cyc(4);
    check("t2 scan row3", row_n, 4'b0111);

    // Two keys in row 0: col0 (1) and col3 (A); lowest column wins.
    n0 = flag_cnt;
    press(0);
    press(3);
    wait_flag("t3", 60, lat);
    check("t3 key_value", key_value, 4'h1);
    unpress(3);
    cyc(40);
    check("t3 one flag", flag_cnt - n0, 1);
    check("t3 still down", key_down, 1'b1);
    unpress(0);
    cyc(40);
    check("t3 released", key_down, 1'b0);

    // Long hold of key 0 (row3/col1), then a second press.
    n0 = flag_cnt;
    press(13);
    cyc(300);
    check("t4 one flag", flag_cnt - n0, 1);
    check("t4 key_value", key_value, 4'h0);
    unpress(13);
    cyc(30);
    press(13);
    wait_flag("t4 repress", 60, lat);
    check("t4 second flag", flag_cnt - n0, 2);
    check("t4 key_value again", key_value, 4'h0);
    unpress(13);
    cyc(40);

    // Sequence 1, 2, A, 3, E.
    n0   = flag_cnt;
    base = flag_log.size();
    for (int i = 0; i < 5; i++) begin
      press(seq_idx[i]);
      cyc(40);
      unpress(seq_idx[i]);
      cyc(40);
    end
    check("t5 five flags", flag_cnt - n0, 5);
    for (int i = 0; i < 5; i++)
      if (base + i < flag_log.size()) check($sformatf("t5 key %0d", i), flag_log[base+i], seq_exp[i]);

    // Reset in the middle of debouncing key 5 (row1/col1).
    n0 = flag_cnt;
    press(5);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 60 && !hit; i++) begin
        cyc(1);
        if (m_mode == M_CONFIRM && m_run == 10) hit = 1'b1;
      end
      check("t6 reached debounce", 32'(hit), 32'd1);
    end
    #1 RST = 1'b0;
    #1;
    check("t6 rst flag", flag, 1'b0);
    check("t6 rst key_down", key_down, 1'b0);
    check("t6 rst row_n", row_n, 4'b1110);
    check("t6 rst key_value", key_value, 4'h0);
    cyc(3);
    RST = 1'b1;
    wait_flag("t6", 60, lat);
    check("t6 key_value", key_value, 4'h5);
    cyc(5);
    check("t6 one flag", flag_cnt - n0, 1);
    unpress(5);
    cyc(40);
    check("t6 released", key_down, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
